// File: rtl/cpu_ula_sched.sv
// rtl/cpu_ula_sched.sv - two-port round-robin scheduler in front of the shared 16-bit ULA
// Optional WAIT timeout enabled by defining CPU_ULA_SCHED_TIMEOUT_EN (bound set by TIMEOUT_CYCLES).
module cpu_ula_sched #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic [2:0]  a_op_code,
    input  logic [15:0] a_src1,
    input  logic [15:0] a_src2,
    input  logic        b_req,
    input  logic [2:0]  b_op_code,
    input  logic [15:0] b_src1,
    input  logic [15:0] b_src2,
    output logic        a_ack,
    output logic        b_ack,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic [2:0]  ula_op_code,
    output logic [15:0] ula_src1,
    output logic [15:0] ula_src2,
    input  logic [15:0] ula_result,
    input  logic        ula_done
);

`ifdef CPU_ULA_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q;
    logic              last_grant_q;  // 0: A served last, 1: B served last
    logic              sel_q;         // 0: port A owns the operation, 1: port B
    logic [2:0]        ula_op_q;
    logic [15:0]       src1_q;
    logic [15:0]       src2_q;
    logic              a_ack_q;
    logic              b_ack_q;
    logic [15:0]       rsp_result_q;
    logic              rsp_err_q;
    logic [TMO_W-1:0]  tmo_cnt_q;

    logic              grant_any_d;
    logic              grant_b_d;
    logic [2:0]        sel_op_d;
    logic [15:0]       sel_src1_d;
    logic [15:0]       sel_src2_d;
    logic              op_valid_d;
    logic              tmo_hit_d;

    // B wins a tie only when A was the last port served
    always_comb begin
        grant_any_d = a_req | b_req;
        grant_b_d   = b_req & (~a_req | ~last_grant_q);
        sel_op_d    = grant_b_d ? b_op_code : a_op_code;
        sel_src1_d  = grant_b_d ? b_src1 : a_src1;
        sel_src2_d  = grant_b_d ? b_src2 : a_src2;
        op_valid_d  = (sel_op_d != 3'd0) && (sel_op_d <= 3'd5);
        tmo_hit_d   = TMO_EN && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            ula_op_q     <= 3'd0;
            src1_q       <= 16'd0;
            src2_q       <= 16'd0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            rsp_result_q <= 16'd0;
            rsp_err_q    <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_any_d) begin
                        sel_q  <= grant_b_d;
                        src1_q <= sel_src1_d;
                        src2_q <= sel_src2_d;
                        if (op_valid_d) begin
                            ula_op_q <= sel_op_d;
                            state_q  <= S_ISSUE;
                        end else begin
                            rsp_result_q <= 16'd0;
                            rsp_err_q    <= 1'b1;
                            a_ack_q      <= ~grant_b_d;
                            b_ack_q      <= grant_b_d;
                            state_q      <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    ula_op_q  <= 3'd0;
                    tmo_cnt_q <= '0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (ula_done) begin
                        rsp_result_q <= ula_result;
                        rsp_err_q    <= 1'b0;
                        a_ack_q      <= ~sel_q;
                        b_ack_q      <= sel_q;
                        state_q      <= S_RESP;
                    end else if (tmo_hit_d) begin
                        rsp_result_q <= 16'd0;
                        rsp_err_q    <= 1'b1;
                        a_ack_q      <= ~sel_q;
                        b_ack_q      <= sel_q;
                        state_q      <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                S_RESP: begin
                    a_ack_q      <= 1'b0;
                    b_ack_q      <= 1'b0;
                    rsp_err_q    <= 1'b0;
                    last_grant_q <= sel_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a_ack       = a_ack_q;
    assign b_ack       = b_ack_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_err     = rsp_err_q;
    assign ula_op_code = ula_op_q;
    assign ula_src1    = src1_q;
    assign ula_src2    = src2_q;

endmodule

// File: doc/cpu_ula_sched.md
# cpu_ula_sched

Two-port round-robin scheduler that shares the single 16-bit ULA between two requesters, for example the instruction-execute path and an address/auxiliary path. It accepts one operation at a time, issues it to the ULA with the one-cycle op_code pulse the ULA expects, and waits for `done`. It then returns the result to the winning requester with a one-cycle acknowledge. Invalid opcodes are rejected locally without touching the ULA.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 8: maximum WAIT cycles before abort. Used only when `CPU_ULA_SCHED_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-low.
- `a_req`, `b_req`  in  1  request from port A / B; held high until the matching ack.
- `a_op_code`, `b_op_code`  in  3  ULA opcode: ADD=1, ADDI=2, SUB=3, SUBI=4, MUL=5.
- `a_src1`, `a_src2`, `b_src1`, `b_src2`  in  16  operands, stable while req is high.
- `a_ack`, `b_ack`  out  1  one-cycle pulse; the response is valid in that cycle.
- `rsp_result`  out  16  shared result bus, meaningful only while an ack is high.
- `rsp_err`  out  1  qualifies the ack: invalid opcode, or timeout if that feature is enabled.
- `ula_op_code`  out  3  to ULA `op_code`.
- `ula_src1`, `ula_src2`  out  16  to ULA `src1`/`src2`.
- `ula_result`  in  16  from ULA `op_result`.
- `ula_done`  in  1  from ULA `done`.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP. All registered.
- **IDLE:**
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port that was not served last (`last_grant` register; port A wins after reset).
  - On grant, latch the port's op_code, src1 and src2 into internal registers and record the selected port.
  - If the latched opcode is 1–5, go to ISSUE. Otherwise (0, 6, 7), set the error flag and result 0, and go directly to RESP.
- **ISSUE:** drive `ula_op_code` with the latched opcode for exactly this cycle, then go to WAIT.
- **WAIT:**
  - `ula_op_code` = 0, so the ULA returns to START and does not re-trigger.
  - When `ula_done` is 1, capture `ula_result` and go to RESP.
- **RESP:**
  - Pulse the selected port's ack for one cycle.
  - Drive `rsp_result` = captured result and `rsp_err` = the error flag.
  - Update `last_grant` to the selected port, then return to IDLE.
- **Operand hold:** `ula_src1`/`ula_src2` are driven from the latched operands in every state, so they stay stable from ISSUE until the ULA has sampled them.
- **Outputs outside RESP:** `ula_op_code` is 0 in every state except ISSUE. `a_ack`, `b_ack` and `rsp_err` are 0 outside RESP.
- **Requester obligations:**
  - Keep `req` and the operands stable until the ack.
  - Deassert `req` in the cycle after the ack, or keep it high to request a new operation.
  - Inputs are re-sampled in IDLE.
- **Arithmetic:** none inside this block. The result is passed through unmodified.

## Timing
- **Reset:** a low `reset` at a clock edge forces the following, regardless of state:
  - state = IDLE, `last_grant` = B (so A has priority next);
  - `ula_op_code` = 0, `ula_src1` = `ula_src2` = 0;
  - `a_ack` = `b_ack` = 0, `rsp_result` = 0, `rsp_err` = 0.

  An in-flight operation is dropped with no ack. The ULA is reset independently.
- **Latency, valid op:** with the request sampled in IDLE at cycle 0:
  - ISSUE at cycle 1;
  - ULA CALCULATE at cycle 2;
  - ULA FINISH, `ula_done` = 1 at cycle 3;
  - RESP / ack at cycle 4.

  Total 4 cycles from grant to ack, and 5 cycles per operation when requests are back-to-back.
- **Latency, invalid opcode:** ack with `rsp_err` = 1 and `rsp_result` = 0 at cycle 1.
- **Request changes:** a req that rises during ISSUE, WAIT or RESP waits for the next IDLE cycle. A req that drops before its grant is simply not served.
- **Arbitration under load:** with both requests continuously high, grants alternate A, B, A, B…
- **`ula_done` outside WAIT:** ignored.

## Configuration
- **`CPU_ULA_SCHED_TIMEOUT_EN` defined:**
  - A counter runs in WAIT.
  - If `ula_done` has not been seen after `TIMEOUT_CYCLES` WAIT cycles, go to RESP with `rsp_err` = 1 and `rsp_result` = 0.
  - `ula_op_code` stays 0.
- **Not defined:** WAIT lasts until `ula_done` with no bound, and `rsp_err` is only ever set for invalid opcodes.

## Test plan
- **Single ADD:** A requests ADD, src1=0x0003, src2=0x0004 -> `a_ack` 4 cycles after grant with `rsp_result`=0x0007 and `rsp_err`=0; `ula_op_code`=1 for exactly one cycle.
- **Simultaneous requests:** A requests SUB 10−3 and B requests MUL 6×7, both in the same cycle after reset -> A served first with 0x0007, then B with 0x002A; `b_ack` comes 5 cycles after `a_ack`.
- **Continuous requests:** both requests held high for 4 operations -> ack order A, B, A, B; `ula_op_code` never stays non-zero for two consecutive cycles.
- **Invalid opcode:** B requests opcode 7 -> `b_ack` one cycle after grant with `rsp_err`=1 and `rsp_result`=0; `ula_op_code` stays 0.
- **Reset mid-operation:** `reset`=0 during WAIT of an ADDI -> no ack and all outputs 0 next cycle; after reset is released, A gets priority over a simultaneous B.
- **Timeout (macro defined, TIMEOUT_CYCLES=8):** `ula_done` tied to 0 -> ack after ISSUE plus 8 WAIT cycles with `rsp_err`=1 and `rsp_result`=0.
